// File: rtl/sme_host.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sme_host                                                     |
// | Purpose  : Serializes a buffered string/pattern onto the string-match   |
// |            engine's character port and returns the engine's result.     |
// |            Optional watchdog on the result wait: SME_HOST_TIMEOUT_EN.   |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module sme_host #(
  parameter int TO_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_str_we,
  input  logic [4:0] ld_str_addr,
  input  logic [7:0] ld_str_data,
  input  logic [4:0] ld_str_len,
  input  logic       ld_pat_we,
  input  logic [2:0] ld_pat_addr,
  input  logic [7:0] ld_pat_data,
  input  logic [2:0] ld_pat_len,
  input  logic       start,
  input  logic       start_pat_only,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_S = 3'd1,
    SEND_P = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0] r_str_len, w_str_len_nxt;
  logic [2:0] r_pat_len, w_pat_len_nxt;
  logic [7:0] r_str_buf [32];
  logic [7:0] r_pat_buf [8];
  logic [7:0] w_str_first, w_pat_first;
  logic       w_wr_ok, w_timeout;
  logic       w_busy_nxt, w_isstring_nxt, w_ispattern_nxt;
  logic [7:0] w_chardata_nxt;
  logic       w_res_valid_nxt, w_res_match_nxt, w_res_timeout_nxt;
  logic [4:0] w_res_index_nxt;

  assign w_wr_ok   = !busy;
  assign w_cnt_inc = r_cnt + 5'd1;

  always_ff @(posedge clk) begin
    if (w_wr_ok && ld_str_we) r_str_buf[ld_str_addr] <= ld_str_data;
    if (w_wr_ok && ld_pat_we) r_pat_buf[ld_pat_addr] <= ld_pat_data;
  end

  // A write coinciding with start must reach the first transmitted character.
  assign w_str_first = (ld_str_we && ld_str_addr == 5'd0) ? ld_str_data : r_str_buf[0];
  assign w_pat_first = (ld_pat_we && ld_pat_addr == 3'd0) ? ld_pat_data : r_pat_buf[0];

`ifdef SME_HOST_TIMEOUT_EN
  logic [9:0] r_to_cnt;
  always_ff @(posedge clk) begin
    if (reset || r_state != WAIT) r_to_cnt <= 10'd0;
    else                          r_to_cnt <= r_to_cnt + 10'd1;
  end
  assign w_timeout = (r_state == WAIT) && (r_to_cnt == 10'(TO_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_str_len_nxt     = r_str_len;
    w_pat_len_nxt     = r_pat_len;
    w_busy_nxt        = busy;
    w_chardata_nxt    = 8'd0;
    w_isstring_nxt    = 1'b0;
    w_ispattern_nxt   = 1'b0;
    w_res_valid_nxt   = 1'b0;
    w_res_match_nxt   = res_match;
    w_res_index_nxt   = res_index;
    w_res_timeout_nxt = res_timeout;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        if (start) begin
          w_str_len_nxt = ld_str_len;
          w_pat_len_nxt = ld_pat_len;
          w_cnt_nxt     = 5'd0;
          w_busy_nxt    = 1'b1;
          if (start_pat_only) begin
            w_state_nxt     = SEND_P;
            w_chardata_nxt  = w_pat_first;
            w_ispattern_nxt = 1'b1;
          end else begin
            w_state_nxt    = SEND_S;
            w_chardata_nxt = w_str_first;
            w_isstring_nxt = 1'b1;
          end
        end
      end
      SEND_S: begin
        if (r_cnt == r_str_len) begin
          w_state_nxt     = SEND_P;
          w_cnt_nxt       = 5'd0;
          w_chardata_nxt  = r_pat_buf[0];
          w_ispattern_nxt = 1'b1;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_chardata_nxt = r_str_buf[w_cnt_inc];
          w_isstring_nxt = 1'b1;
        end
      end
      SEND_P: begin
        if (r_cnt == {2'b00, r_pat_len}) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt       = w_cnt_inc;
          w_chardata_nxt  = r_pat_buf[w_cnt_inc[2:0]];
          w_ispattern_nxt = 1'b1;
        end
      end
      WAIT: begin
        // A result strobe on the watchdog's final cycle takes priority.
        if (valid) begin
          w_state_nxt       = DONE;
          w_busy_nxt        = 1'b0;
          w_res_valid_nxt   = 1'b1;
          w_res_match_nxt   = match;
          w_res_index_nxt   = match ? match_index : 5'd0;
          w_res_timeout_nxt = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt       = DONE;
          w_busy_nxt        = 1'b0;
          w_res_valid_nxt   = 1'b1;
          w_res_match_nxt   = 1'b0;
          w_res_index_nxt   = 5'd0;
          w_res_timeout_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_str_len   <= 5'd0;
      r_pat_len   <= 3'd0;
      busy        <= 1'b0;
      chardata    <= 8'd0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      res_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_str_len   <= w_str_len_nxt;
      r_pat_len   <= w_pat_len_nxt;
      busy        <= w_busy_nxt;
      chardata    <= w_chardata_nxt;
      isstring    <= w_isstring_nxt;
      ispattern   <= w_ispattern_nxt;
      res_valid   <= w_res_valid_nxt;
      res_match   <= w_res_match_nxt;
      res_index   <= w_res_index_nxt;
      res_timeout <= w_res_timeout_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sme_host.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sme_host                                                  |
// | Purpose  : Randomized scoreboard bench for sme_host with an engine model.|
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sme_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_str_we, ld_pat_we, start, start_pat_only;
  logic [4:0] ld_str_addr, ld_str_len;
  logic [7:0] ld_str_data, ld_pat_data;
  logic [2:0] ld_pat_addr, ld_pat_len;
  logic       busy, isstring, ispattern;
  logic [7:0] chardata;
  logic       valid, match;
  logic [4:0] match_index;
  logic       res_valid, res_match, res_timeout;
  logic [4:0] res_index;

  sme_host dut (
    .clk(clk), .reset(reset),
    .ld_str_we(ld_str_we), .ld_str_addr(ld_str_addr), .ld_str_data(ld_str_data),
    .ld_str_len(ld_str_len),
    .ld_pat_we(ld_pat_we), .ld_pat_addr(ld_pat_addr), .ld_pat_data(ld_pat_data),
    .ld_pat_len(ld_pat_len),
    .start(start), .start_pat_only(start_pat_only), .busy(busy),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] ch; bit is_str; int at; } chr_t;
  typedef struct { bit m; logic [4:0] idx; bit to; int at; } res_t;
  chr_t exp_c[$];
  res_t exp_r[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] str_m [32];
  logic [7:0] pat_m [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every character and result is matched against the queues.
  always @(negedge clk) begin
    chr_t ec;
    res_t er;
    if (!reset) begin
      if (isstring || ispattern) begin
        if (exp_c.size() == 0) check("unexpected_char", {isstring, ispattern, chardata}, 64'd0);
        else begin
          ec = exp_c.pop_front();
          check("char", {cyc, isstring, ispattern, chardata}, {ec.at, ec.is_str, !ec.is_str, ec.ch});
        end
      end else begin
        check("quiet_chardata", {56'd0, chardata}, 64'd0);
      end
      if (res_valid) begin
        if (exp_r.size() == 0) check("unexpected_result", {res_match, res_index}, 64'd0);
        else begin
          er = exp_r.pop_front();
          check("result", {cyc, res_match, res_index, res_timeout, busy},
                {er.at, er.m, er.idx, er.to, 1'b0});
        end
      end
    end
  end

  // Engine model: answers after a short random delay once the pattern has been sent.
  initial begin : engine
    bit saw_pat;
    int dly;
    saw_pat = 0; dly = 0;
    valid = 0; match = 0; match_index = 0;
    forever begin
      @(negedge clk);
      valid = 0;
      if (reset) saw_pat = 0;
      else if (ispattern) begin
        saw_pat = 1;
        dly = $urandom_range(0, 3);
      end else if (saw_pat && busy) begin
        if (dly == 0) begin
          valid = 1;
          match = 1'($urandom_range(0, 1));
          match_index = 5'($urandom);
          exp_r.push_back('{m: match, idx: (match ? match_index : 5'd0), to: 1'b0, at: cyc + 1});
          saw_pat = 0;
        end else dly--;
      end else if (!busy || isstring) begin
        if ($urandom_range(0, 3) == 0) begin
          valid = 1; match = 1; match_index = 5'($urandom);
        end
      end
    end
  end

  task automatic idle_ins();
    ld_str_we = 0; ld_pat_we = 0; start = 0;
  endtask

  task automatic push_chars(input bit po, input int sl, input int pl, input int first);
    int k = first;
    if (!po) for (int i = 0; i <= sl; i++) begin
      exp_c.push_back('{ch: str_m[i], is_str: 1'b1, at: k}); k++;
    end
    for (int i = 0; i <= pl; i++) begin
      exp_c.push_back('{ch: pat_m[i], is_str: 1'b0, at: k}); k++;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) str_m[i] = 8'($urandom_range(32, 126));
    for (int i = 0; i < 8; i++)  pat_m[i] = 8'($urandom_range(32, 126));
  endtask

  task automatic issue_start(input bit po, input int sl, input int pl);
    ld_str_len = 5'(sl); ld_pat_len = 3'(pl); start_pat_only = po; start = 1;
    push_chars(po, sl, pl, cyc + 1);
  endtask

  // Loads both buffers; address 0 is written in the same cycle as start.
  task automatic load_and_start(input bit po, input int sl, input int pl);
    for (int i = 1; i < 32; i++) begin
      ld_str_we = 1; ld_str_addr = 5'(i); ld_str_data = str_m[i];
      ld_pat_we = (i < 8); ld_pat_addr = 3'(i); ld_pat_data = pat_m[i % 8];
      start = 0;
      @(negedge clk);
    end
    ld_str_we = 1; ld_str_addr = 5'd0; ld_str_data = str_m[0];
    ld_pat_we = 1; ld_pat_addr = 3'd0; ld_pat_data = pat_m[0];
    issue_start(po, sl, pl);
  endtask

  // Runs from the start cycle until the result; junk writes/starts while busy.
  task automatic run_txn(input bit chain, input bit npo, input int nsl, input int npl);
    int n = 0;
    @(negedge clk);
    idle_ins();
    check("busy_after_start", {63'd0, busy}, 64'd1);
    forever begin
      if (res_valid) break;
      if (n == 300) begin
        check("result_timeout", 64'd0, 64'd1);
        break;
      end
      if (busy) begin
        ld_str_we = 1'($urandom_range(0, 1)); ld_str_addr = 5'($urandom); ld_str_data = 8'($urandom);
        ld_pat_we = 1'($urandom_range(0, 1)); ld_pat_addr = 3'($urandom); ld_pat_data = 8'($urandom);
        start = 1'($urandom_range(0, 1)); start_pat_only = 1'($urandom_range(0, 1));
        ld_str_len = 5'($urandom); ld_pat_len = 3'($urandom);
      end else idle_ins();
      @(negedge clk);
      n++;
    end
    idle_ins();
    if (chain) issue_start(npo, nsl, npl);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit chained, po, nchain, npo;
    int sl, pl, nsl, npl;
    reset = 1; idle_ins(); start_pat_only = 0;
    ld_str_addr = 0; ld_str_data = 0; ld_pat_addr = 0; ld_pat_data = 0;
    ld_str_len = 0; ld_pat_len = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout}, 64'd0);
    reset = 0;
    @(negedge clk);

    // "abcd" then "bc"
    fill_rand();
    str_m[0] = 8'h61; str_m[1] = 8'h62; str_m[2] = 8'h63; str_m[3] = 8'h64;
    pat_m[0] = 8'h62; pat_m[1] = 8'h63;
    load_and_start(0, 3, 1);
    run_txn(0, 0, 0, 0);

    // pattern-only "^x"
    fill_rand();
    pat_m[0] = 8'h5E; pat_m[1] = 8'h78;
    load_and_start(1, 7, 1);
    run_txn(0, 0, 0, 0);

    // maximum lengths, then a back-to-back start on the same buffers
    fill_rand();
    load_and_start(0, 31, 7);
    run_txn(1, 0, 31, 7);
    run_txn(0, 0, 0, 0);

    // reset while the third string character is on the bus
    fill_rand();
    load_and_start(0, 10, 3);
    repeat (3) begin
      @(negedge clk);
      idle_ins();
    end
    #1 reset = 1;
    exp_c.delete();
    @(negedge clk);
    check("mid_reset_outputs", {busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout}, 64'd0);
    #1 reset = 0;
    @(negedge clk);

    chained = 0;
    po = 0; sl = 5; pl = 2;
    for (int t = 0; t < 30; t++) begin
      if (!chained) begin
        po = ($urandom_range(0, 3) == 0);
        sl = $urandom_range(0, 31);
        pl = $urandom_range(0, 7);
        fill_rand();
        load_and_start(po, sl, pl);
      end
      nchain = (t < 29) && ($urandom_range(0, 2) == 0);
      npo = ($urandom_range(0, 3) == 0);
      nsl = $urandom_range(0, 31);
      npl = $urandom_range(0, 7);
      run_txn(nchain, npo, nsl, npl);
      chained = nchain; po = npo; sl = nsl; pl = npl;
    end

    repeat (6) @(negedge clk);
    check("chars_drained", 64'(exp_c.size()), 64'd0);
    check("results_drained", 64'(exp_r.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
